// File: rtl/isp_awb_pkg.sv
// Shared types and constants for the gray-world auto white balance stage.
// Gains are unsigned Q4.8 (GAIN_ONE is unity).
package isp_awb_pkg;

    localparam int GAIN_W    = 12;
    localparam int GAIN_FRAC = 8;
    localparam logic [GAIN_W-1:0] GAIN_ONE = 12'd256;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 12'd4095;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV_R  = 2'd1,
        ST_DIV_B  = 2'd2,
        ST_COMMIT = 2'd3
    } awb_state_e;

    // Clip a raw quotient into the gain range; a zero divisor means "leave the channel at unity".
    function automatic logic [GAIN_W-1:0] sat_gain(input logic [63:0] quot, input logic dbz);
        logic [GAIN_W-1:0] res;
        if (dbz) begin
            res = GAIN_ONE;
        end else if (quot > {52'd0, GAIN_MAX}) begin
            res = GAIN_MAX;
        end else begin
            res = quot[GAIN_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/isp_awb_gray_world_if.sv
// Pixel-stream bus of the AWB stage: sync/valid/RGB in, balanced RGB, active gains and busy out.
// Manual-gain signals exist only when ISP_AWB_MANUAL_EN is defined.
interface isp_awb_gray_world_if #(
    parameter int DATA_WIDTH = 8
) ();
    import isp_awb_pkg::*;

    logic                  vsync_i;
    logic                  valid_i;
    logic [DATA_WIDTH-1:0] r_i;
    logic [DATA_WIDTH-1:0] g_i;
    logic [DATA_WIDTH-1:0] b_i;
`ifdef ISP_AWB_MANUAL_EN
    logic                  manual_i;
    logic [GAIN_W-1:0]     man_gain_r_i;
    logic [GAIN_W-1:0]     man_gain_b_i;
`endif
    logic                  vsync_o;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] r_o;
    logic [DATA_WIDTH-1:0] g_o;
    logic [DATA_WIDTH-1:0] b_o;
    logic [GAIN_W-1:0]     gain_r_o;
    logic [GAIN_W-1:0]     gain_b_o;
    logic                  busy_o;

    modport master (
        output vsync_i, valid_i, r_i, g_i, b_i,
`ifdef ISP_AWB_MANUAL_EN
        output manual_i, man_gain_r_i, man_gain_b_i,
`endif
        input  vsync_o, valid_o, r_o, g_o, b_o, gain_r_o, gain_b_o, busy_o
    );

    modport slave (
        input  vsync_i, valid_i, r_i, g_i, b_i,
`ifdef ISP_AWB_MANUAL_EN
        input  manual_i, man_gain_r_i, man_gain_b_i,
`endif
        output vsync_o, valid_o, r_o, g_o, b_o, gain_r_o, gain_b_o, busy_o
    );

endinterface

// File: rtl/isp_awb_div.sv
// Serial restoring divider: one quotient bit per cycle, DVD_W cycles from start to done.
// The start cycle already performs the first iteration on the presented operands.
module isp_awb_div #(
    parameter int DVD_W = 36,
    parameter int DVS_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic             div_by_zero
);
    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DVS_W-1:0] rem_r;
    logic [DVD_W-1:0] quo_r;
    logic [DVS_W-1:0] dvs_r;
    logic [CNT_W-1:0] cnt_r;
    logic             run_r;
    logic             done_r;
    logic             dbz_r;

    logic [DVS_W-1:0] rem_src_s;
    logic [DVD_W-1:0] quo_src_s;
    logic [DVS_W-1:0] dvs_src_s;
    logic [DVS_W:0]   trial_s;
    logic [DVS_W:0]   diff_s;
    logic [DVS_W-1:0] rem_nxt_s;
    logic [DVD_W-1:0] quo_nxt_s;

    // One restoring step: shift the next dividend bit into the remainder and try a subtract.
    always_comb begin
        rem_src_s = rem_r;
        quo_src_s = quo_r;
        dvs_src_s = dvs_r;
        if (start) begin
            rem_src_s = {DVS_W{1'b0}};
            quo_src_s = dividend;
            dvs_src_s = divisor;
        end else begin
            rem_src_s = rem_r;
            quo_src_s = quo_r;
            dvs_src_s = dvs_r;
        end
        trial_s = {rem_src_s, quo_src_s[DVD_W-1]};
        diff_s  = trial_s - {1'b0, dvs_src_s};
        if (trial_s >= {1'b0, dvs_src_s}) begin
            rem_nxt_s = diff_s[DVS_W-1:0];
            quo_nxt_s = {quo_src_s[DVD_W-2:0], 1'b1};
        end else begin
            rem_nxt_s = trial_s[DVS_W-1:0];
            quo_nxt_s = {quo_src_s[DVD_W-2:0], 1'b0};
        end
    end

    // Iteration state, bit counter and the one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r  <= {DVS_W{1'b0}};
            quo_r  <= {DVD_W{1'b0}};
            dvs_r  <= {DVS_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            run_r  <= 1'b0;
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
        end else if (start) begin
            rem_r  <= rem_nxt_s;
            quo_r  <= quo_nxt_s;
            dvs_r  <= divisor;
            dbz_r  <= (divisor == {DVS_W{1'b0}});
            cnt_r  <= CNT_LAST;
            run_r  <= 1'b1;
            done_r <= 1'b0;
        end else if (run_r) begin
            rem_r <= rem_nxt_s;
            quo_r <= quo_nxt_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r <= 1'b0;
        end
    end

    assign done        = done_r;
    assign quotient    = quo_r;
    assign div_by_zero = dbz_r;

endmodule

// File: rtl/isp_awb_gray_world.sv
// Gray-world AWB: per-frame RGB statistics, serial R/B gain computation in blanking, 3-stage apply.
// Define ISP_AWB_MANUAL_EN to add a per-cycle manual gain override on the bus.
module isp_awb_gray_world
    import isp_awb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PIX_CNT_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    isp_awb_gray_world_if.slave bus
);
    localparam int ACC_W  = DATA_WIDTH + PIX_CNT_W;
    localparam int DVD_W  = ACC_W + GAIN_FRAC;
    localparam int PROD_W = DATA_WIDTH + GAIN_W;

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                                 input logic [DATA_WIDTH-1:0] pix);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(PIX_CNT_W + 1){1'b0}}, pix};
        if (sum[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

    // Round-half-up back to pixel scale, clamping anything above full scale.
    function automatic logic [DATA_WIDTH-1:0] round_clamp(input logic [PROD_W-1:0] prod);
        logic [PROD_W:0] rnd;
        rnd = {1'b0, prod} + {{(PROD_W + 1 - GAIN_FRAC){1'b0}}, 1'b1, {(GAIN_FRAC - 1){1'b0}}};
        if (|rnd[PROD_W:GAIN_FRAC+DATA_WIDTH]) begin
            return {DATA_WIDTH{1'b1}};
        end else begin
            return rnd[GAIN_FRAC+DATA_WIDTH-1:GAIN_FRAC];
        end
    endfunction

    logic                  vsync_d_r;
    logic                  edge_s;
    logic                  start_run_s;
    logic [ACC_W-1:0]      acc_red_r, acc_grn_r, acc_blu_r;
    logic [ACC_W-1:0]      snap_red_r, snap_grn_r, snap_blu_r;
    logic [PIX_CNT_W-1:0]  pix_cnt_r;
    awb_state_e            state_r, state_nxt_s;
    logic                  busy_r, kick_r;
    logic                  div_start_s, div_done_s, div_dbz_s;
    logic [DVD_W-1:0]      div_dividend_s, div_quot_s;
    logic [ACC_W-1:0]      div_divisor_s;
    logic [GAIN_W-1:0]     pend_gain_r_r, pend_gain_b_r;
    logic [GAIN_W-1:0]     gain_r_r, gain_b_r;
    logic [GAIN_W-1:0]     eff_gain_r_s, eff_gain_b_s;
    logic                  s1_vld_r, s1_vs_r, s2_vld_r, s2_vs_r, s3_vld_r, s3_vs_r;
    logic [DATA_WIDTH-1:0] s1_r_r, s1_g_r, s1_b_r, s2_g_r, s3_r_r, s3_g_r, s3_b_r;
    logic [PROD_W-1:0]     s2_prod_r_r, s2_prod_b_r;

    assign edge_s      = bus.vsync_i & ~vsync_d_r;
    assign start_run_s = edge_s & (state_r == ST_IDLE) & (pix_cnt_r != {PIX_CNT_W{1'b0}});

    // Frame statistics; a frame edge clears them and the edge-cycle pixel seeds the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d_r <= 1'b0;
            acc_red_r <= {ACC_W{1'b0}};
            acc_grn_r <= {ACC_W{1'b0}};
            acc_blu_r <= {ACC_W{1'b0}};
            pix_cnt_r <= {PIX_CNT_W{1'b0}};
        end else begin
            vsync_d_r <= bus.vsync_i;
            if (edge_s) begin
                acc_red_r <= bus.valid_i ? {{PIX_CNT_W{1'b0}}, bus.r_i} : {ACC_W{1'b0}};
                acc_grn_r <= bus.valid_i ? {{PIX_CNT_W{1'b0}}, bus.g_i} : {ACC_W{1'b0}};
                acc_blu_r <= bus.valid_i ? {{PIX_CNT_W{1'b0}}, bus.b_i} : {ACC_W{1'b0}};
                pix_cnt_r <= bus.valid_i ? {{(PIX_CNT_W-1){1'b0}}, 1'b1} : {PIX_CNT_W{1'b0}};
            end else if (bus.valid_i) begin
                acc_red_r <= sat_acc(acc_red_r, bus.r_i);
                acc_grn_r <= sat_acc(acc_grn_r, bus.g_i);
                acc_blu_r <= sat_acc(acc_blu_r, bus.b_i);
                if (pix_cnt_r != {PIX_CNT_W{1'b1}}) begin
                    pix_cnt_r <= pix_cnt_r + {{(PIX_CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    pix_cnt_r <= pix_cnt_r;
                end
            end else begin
                pix_cnt_r <= pix_cnt_r;
            end
        end
    end

    // Next-state logic of the gain computation sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_run_s) state_nxt_s = ST_DIV_R;
                else             state_nxt_s = ST_IDLE;
            end
            ST_DIV_R: begin
                if (div_done_s) state_nxt_s = ST_DIV_B;
                else            state_nxt_s = ST_DIV_R;
            end
            ST_DIV_B: begin
                if (div_done_s) state_nxt_s = ST_COMMIT;
                else            state_nxt_s = ST_DIV_B;
            end
            ST_COMMIT: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // The B division is launched in the very cycle the R result arrives.
    assign div_start_s    = kick_r | ((state_r == ST_DIV_R) & div_done_s);
    assign div_dividend_s = {snap_grn_r, {GAIN_FRAC{1'b0}}};
    assign div_divisor_s  = kick_r ? snap_red_r : snap_blu_r;

    isp_awb_div #(.DVD_W(DVD_W), .DVS_W(ACC_W)) u_div (
        .clk         (clk),
        .rst         (rst),
        .start       (div_start_s),
        .dividend    (div_dividend_s),
        .divisor     (div_divisor_s),
        .done        (div_done_s),
        .quotient    (div_quot_s),
        .div_by_zero (div_dbz_s)
    );

    // Sequencer state, snapshot (only taken when idle) and the gain registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            kick_r        <= 1'b0;
            snap_red_r    <= {ACC_W{1'b0}};
            snap_grn_r    <= {ACC_W{1'b0}};
            snap_blu_r    <= {ACC_W{1'b0}};
            pend_gain_r_r <= GAIN_ONE;
            pend_gain_b_r <= GAIN_ONE;
            gain_r_r      <= GAIN_ONE;
            gain_b_r      <= GAIN_ONE;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            kick_r  <= start_run_s;
            if (edge_s && (state_r == ST_IDLE)) begin
                snap_red_r <= acc_red_r;
                snap_grn_r <= acc_grn_r;
                snap_blu_r <= acc_blu_r;
            end
            if ((state_r == ST_DIV_R) && div_done_s) begin
                pend_gain_r_r <= sat_gain(64'(div_quot_s), div_dbz_s);
            end
            if ((state_r == ST_DIV_B) && div_done_s) begin
                pend_gain_b_r <= sat_gain(64'(div_quot_s), div_dbz_s);
            end
            if (state_r == ST_COMMIT) begin
                gain_r_r <= pend_gain_r_r;
                gain_b_r <= pend_gain_b_r;
            end
        end
    end

`ifdef ISP_AWB_MANUAL_EN
    logic              manual_r;
    logic [GAIN_W-1:0] man_gain_r_r, man_gain_b_r;

    // Manual override sampled every cycle; computed gains are kept underneath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            manual_r     <= 1'b0;
            man_gain_r_r <= GAIN_ONE;
            man_gain_b_r <= GAIN_ONE;
        end else begin
            manual_r     <= bus.manual_i;
            man_gain_r_r <= bus.man_gain_r_i;
            man_gain_b_r <= bus.man_gain_b_i;
        end
    end

    // Select which gain pair the apply path and gain outputs see.
    always_comb begin
        if (manual_r) begin
            eff_gain_r_s = man_gain_r_r;
            eff_gain_b_s = man_gain_b_r;
        end else begin
            eff_gain_r_s = gain_r_r;
            eff_gain_b_s = gain_b_r;
        end
    end
`else
    // Gains are always the automatically computed ones.
    always_comb begin
        eff_gain_r_s = gain_r_r;
        eff_gain_b_s = gain_b_r;
    end
`endif

    // Apply pipeline: register, multiply by the gains in force, round and clamp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_r <= 1'b0;  s1_vs_r <= 1'b0;
            s2_vld_r <= 1'b0;  s2_vs_r <= 1'b0;
            s3_vld_r <= 1'b0;  s3_vs_r <= 1'b0;
            s1_r_r <= {DATA_WIDTH{1'b0}};
            s1_g_r <= {DATA_WIDTH{1'b0}};
            s1_b_r <= {DATA_WIDTH{1'b0}};
            s2_g_r <= {DATA_WIDTH{1'b0}};
            s2_prod_r_r <= {PROD_W{1'b0}};
            s2_prod_b_r <= {PROD_W{1'b0}};
            s3_r_r <= {DATA_WIDTH{1'b0}};
            s3_g_r <= {DATA_WIDTH{1'b0}};
            s3_b_r <= {DATA_WIDTH{1'b0}};
        end else begin
            s1_vld_r <= bus.valid_i;
            s1_vs_r  <= bus.vsync_i;
            s1_r_r   <= bus.r_i;
            s1_g_r   <= bus.g_i;
            s1_b_r   <= bus.b_i;
            s2_vld_r <= s1_vld_r;
            s2_vs_r  <= s1_vs_r;
            s2_g_r   <= s1_g_r;
            s2_prod_r_r <= {{GAIN_W{1'b0}}, s1_r_r} * {{DATA_WIDTH{1'b0}}, eff_gain_r_s};
            s2_prod_b_r <= {{GAIN_W{1'b0}}, s1_b_r} * {{DATA_WIDTH{1'b0}}, eff_gain_b_s};
            s3_vld_r <= s2_vld_r;
            s3_vs_r  <= s2_vs_r;
            s3_r_r   <= round_clamp(s2_prod_r_r);
            s3_g_r   <= s2_g_r;
            s3_b_r   <= round_clamp(s2_prod_b_r);
        end
    end

    assign bus.vsync_o  = s3_vs_r;
    assign bus.valid_o  = s3_vld_r;
    assign bus.r_o      = s3_r_r;
    assign bus.g_o      = s3_g_r;
    assign bus.b_o      = s3_b_r;
    assign bus.gain_r_o = eff_gain_r_s;
    assign bus.gain_b_o = eff_gain_b_s;
    assign bus.busy_o   = busy_r;

endmodule

// File: tb/tb_isp_awb_gray_world.sv
// Directed bench for isp_awb_gray_world: pass-through, gain update timing, saturation,
// busy-time frame edges, async reset mid-division, empty frames and (if built) manual gains.
module tb_isp_awb_gray_world;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    isp_awb_gray_world_if #(.DATA_WIDTH(8)) bus ();

    isp_awb_gray_world #(.DATA_WIDTH(8), .PIX_CNT_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        bus.valid_i = 1'b1;
        bus.r_i = r;
        bus.g_i = g;
        bus.b_i = b;
    endtask

    task automatic clr_pix();
        bus.valid_i = 1'b0;
        bus.r_i = 8'd0;
        bus.g_i = 8'd0;
        bus.b_i = 8'd0;
    endtask

    // One pixel in, compare the balanced pixel three cycles later.
    task automatic pix_check(input string tag, input logic [7:0] r, input logic [7:0] g,
                             input logic [7:0] b, input int er, input int eg, input int eb);
        set_pix(r, g, b);
        tick(1);
        clr_pix();
        tick(2);
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check({tag, "_r"}, 32'(bus.r_o), er);
        check({tag, "_g"}, 32'(bus.g_o), eg);
        check({tag, "_b"}, 32'(bus.b_o), eb);
    endtask

    task automatic gain_check(input string tag, input int egr, input int egb);
        check({tag, "_gain_r"}, 32'(bus.gain_r_o), egr);
        check({tag, "_gain_b"}, 32'(bus.gain_b_o), egb);
    endtask

    task automatic vsync_pulse();
        bus.vsync_i = 1'b1;
        tick(1);
        bus.vsync_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.vsync_i = 1'b0;
        clr_pix();
`ifdef ISP_AWB_MANUAL_EN
        bus.manual_i = 1'b0;
        bus.man_gain_r_i = 12'd256;
        bus.man_gain_b_i = 12'd256;
`endif
        tick(3);
        check("rst_r", 32'(bus.r_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_vsync", 32'(bus.vsync_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        gain_check("rst", 256, 256);
        rst = 1'b0;
        tick(2);

        // Unity gains pass the pixel straight through.
        pix_check("unity", 8'd64, 8'd128, 8'd32, 64, 128, 32);
        gain_check("unity", 256, 256);

        // Frame 1: 17 pixels of (64,128,32) in total.
        for (int i = 0; i < 16; i++) begin
            set_pix(8'd64, 8'd128, 8'd32);
            tick(1);
        end
        clr_pix();
        bus.vsync_i = 1'b1;                       // edge cycle T0
        check("busy_at_edge", 32'(bus.busy_o), 32'd0);
        tick(1);                                  // T1
        bus.vsync_i = 1'b0;
        check("busy_rise", 32'(bus.busy_o), 32'd1);
        tick(9);                                  // T10: pixel during busy uses old gains
        pix_check("busy_old", 8'd64, 8'd128, 8'd32, 64, 128, 32);
        tick(7);                                  // T20: second edge while busy
        vsync_pulse();                            // T21
        tick(53);                                 // T74
        check("busy_t74", 32'(bus.busy_o), 32'd1);
        gain_check("t74", 256, 256);
        tick(1);                                  // T75
        check("busy_fall", 32'(bus.busy_o), 32'd0);
        gain_check("frame1", 512, 1024);
        tick(80);
        check("one_update_busy", 32'(bus.busy_o), 32'd0);
        gain_check("one_update", 512, 1024);

        // Frame 2 pixel with new gains.
        pix_check("frame2", 8'd64, 8'd128, 8'd32, 128, 128, 128);

        // Edge launches a recompute of the same ratios; stream (1,255,0) meanwhile.
        vsync_pulse();
        for (int i = 0; i < 8; i++) begin
            set_pix(8'd1, 8'd255, 8'd0);
            tick(1);
        end
        clr_pix();
        tick(2);
        check("stream_r", 32'(bus.r_o), 32'd2);
        check("stream_g", 32'(bus.g_o), 32'd255);
        check("stream_b", 32'(bus.b_o), 32'd0);
        tick(64);
        check("recompute_busy", 32'(bus.busy_o), 32'd0);
        gain_check("recompute", 512, 1024);

        // Compute the (1,255,0) frame: R saturates, B has a zero divisor.
        vsync_pulse();
        tick(74);
        gain_check("sat", 4095, 256);

        // Empty frame leaves the gains and busy alone.
        tick(2);
        vsync_pulse();
        check("empty_busy", 32'(bus.busy_o), 32'd0);
        tick(5);
        check("empty_busy_late", 32'(bus.busy_o), 32'd0);
        gain_check("empty", 4095, 256);

        pix_check("clamp", 8'd200, 8'd10, 8'd9, 255, 10, 9);

        // Reset in the middle of the B division.
        vsync_pulse();                            // T1
        set_pix(8'd200, 8'd10, 8'd9);
        tick(49);                                 // T50
        check("pre_rst_busy", 32'(bus.busy_o), 32'd1);
        check("pre_rst_r", 32'(bus.r_o), 32'd255);
        check("pre_rst_valid", 32'(bus.valid_o), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 32'(bus.busy_o), 32'd0);
        check("async_rst_r", 32'(bus.r_o), 32'd0);
        check("async_rst_g", 32'(bus.g_o), 32'd0);
        check("async_rst_valid", 32'(bus.valid_o), 32'd0);
        gain_check("async_rst", 256, 256);
        clr_pix();
        tick(2);
        rst = 1'b0;
        tick(2);

        vsync_pulse();
        check("post_rst_empty_busy", 32'(bus.busy_o), 32'd0);
        tick(3);
        check("post_rst_empty_busy_late", 32'(bus.busy_o), 32'd0);
        gain_check("post_rst", 256, 256);
        pix_check("post_rst", 8'd64, 8'd128, 8'd32, 64, 128, 32);

`ifdef ISP_AWB_MANUAL_EN
        bus.manual_i = 1'b1;
        bus.man_gain_r_i = 12'd128;
        bus.man_gain_b_i = 12'd256;
        pix_check("manual", 8'd200, 8'd10, 8'd9, 100, 10, 9);
        gain_check("manual", 128, 256);
        bus.manual_i = 1'b0;
        pix_check("auto_back", 8'd200, 8'd10, 8'd9, 200, 10, 9);
        gain_check("auto_back", 256, 256);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/isp_awb_gray_world.md
# isp_awb_gray_world

Gray-world auto white balance stage directly downstream of the denoise stage in the ISP chain. It accumulates per-channel R/G/B sums over each frame. During vertical blanking it computes R and B gains that equalise those sums to G, using a serial divider. It applies the gains currently in force to the pixel stream through a 3-cycle pipeline that matches the handshake of the upstream stage.

## Interface
- DATA_WIDTH, 8: bits per colour channel.
- PIX_CNT_W, 20: pixel-count width; a frame has at most 2^PIX_CNT_W pixels. Accumulator width ACC_W = DATA_WIDTH+PIX_CNT_W.
- clk  in  1  pixel clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- vsync_i  in  1  frame sync, active-high; rising edge marks the frame boundary.
- valid_i  in  1  pixel qualifier; r_i/g_i/b_i are sampled only when high.
- r_i, g_i, b_i  in  DATA_WIDTH each  input pixel.
- vsync_o, valid_o  out  1  vsync_i/valid_i delayed 3 cycles.
- r_o, g_o, b_o  out  DATA_WIDTH each  balanced pixel.
- gain_r_o, gain_b_o  out  12  active gains, unsigned Q4.8; 256 = 1.0.
- busy_o  out  1  gain computation in progress.

## Operation
- Stats: on each cycle with valid_i=1, add r_i/g_i/b_i to sum_r/sum_g/sum_b and increment pix_cnt. Each accumulator saturates at all-ones and does not wrap.
- Frame boundary: a vsync_i rising edge is detected by a registered compare. On that edge:
  - Snapshot the sums and pix_cnt.
  - Clear the accumulators. If valid_i=1 in the edge cycle, that pixel seeds the new frame's sums.
  - Start the FSM if it is IDLE.
- FSM states IDLE -> DIV_R -> DIV_B -> COMMIT -> IDLE.
  - IDLE leaves only on a vsync rising edge with snapshot pix_cnt != 0. With pix_cnt == 0, the gains are unchanged.
  - DIV_R computes q = (sum_g<<8)/sum_r. DIV_B computes (sum_g<<8)/sum_b. Each is a restoring divider producing 1 quotient bit per cycle, ACC_W+8 cycles.
  - Each quotient saturates to 4095 if it exceeds 4095.
  - A zero divisor gives gain 256.
  - COMMIT loads gain_r and gain_b together in one cycle.
- A vsync rising edge while busy_o=1: the accumulators clear, the new snapshot is discarded and its frame produces no update. The current computation completes.
- Apply path, per pixel:
  - Stage 1 registers the input.
  - Stage 2 computes r*gain_r and b*gain_b (DATA_WIDTH+12 bits). G passes through.
  - Stage 3 computes (product+128)>>8 and clamps to 2^DATA_WIDTH-1.
- Pixels entering stage 2 in the COMMIT+1 cycle or later use the new gains. Earlier pixels use the old gains. Gains never change within a product.

## Timing
- Latency is 3 cycles for all stream outputs. There is no backpressure; a new pixel can be accepted every cycle.
- Update delay: busy_o rises 1 cycle after the vsync_i edge. The new gains are visible on gain_*_o 2*(ACC_W+8)+2 cycles after busy_o rises: 74 cycles at the defaults.
- Reset values:
  - All stream outputs are 0.
  - busy_o is 0.
  - gain_r_o and gain_b_o are 256.
  - Accumulators are 0; the FSM is IDLE.
- A reset asserted mid-division aborts the computation and returns every register to its reset value asynchronously.

## Configuration
- ISP_AWB_MANUAL_EN:
  - Defined: the block adds manual_i (1), man_gain_r_i (12) and man_gain_b_i (12). While manual_i=1, the apply path and gain_*_o use the manual gains, sampled each cycle. Statistics and the FSM keep running, and the computed gains are retained for use when manual_i drops.
  - Undefined: these ports do not exist and the gains are always automatic.

## Structure
- Shared package isp_awb_pkg holds:
  - GAIN_W=12, GAIN_FRAC=8, GAIN_ONE=256, GAIN_MAX=4095.
  - The FSM state enum.
- Sub-module isp_awb_div is a serial restoring divider. It is parameterised by width and has ports start, dividend, divisor, done, quotient, div_by_zero. It is instantiated once and shared sequentially by DIV_R and DIV_B.

## Test plan
- After reset, with no frame: pixel (64,128,32) -> output (64,128,32) after 3 cycles; gains are 256/256.
- Frame 1: 16 pixels of (64,128,32), then a vsync edge -> gain_r=512, gain_b=1024 after 74 cycles. Frame 2: pixel (64,128,32) -> (128,128,128).
- Frame of (1,255,0) -> gain_r saturates to 4095 and gain_b=256 (zero divisor). Next pixel (200,10,9) -> (255,10,9).
- Pixels streamed while busy_o=1 -> old gains apply. Second vsync edge while busy -> exactly one gain update.
- Reset asserted mid-DIV_B -> busy_o=0, gains 256, outputs 0 immediately. Empty frame (valid_i never high) -> gains unchanged, busy_o stays 0.
- With ISP_AWB_MANUAL_EN: manual_i=1, man_gain_r_i=128 -> r_i=200 gives r_o=100. Drop manual_i -> the automatic gains resume on the next pixel.
